// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receive, transmit and buffering stages.
//
// Contents:
//   UART_DATA_W  width of one UART character in bits
//   byte_t       one received or transmitted character
package uart_pkg;

  localparam int unsigned UART_DATA_W = 8;

  typedef logic [UART_DATA_W-1:0] byte_t;

  localparam byte_t BYTE_ZERO = '0;

endpackage : uart_pkg

// File: rtl/fifo_mem.sv
// Byte storage array for the UART receive FIFO.
// One synchronous write port and one asynchronous (combinational) read port,
// so the FIFO can present its head entry in the same cycle it is addressed.
// Contents are not reset.
//
// Ports:
//   clock    system clock, rising edge
//   wr_en    write strobe; wr_data is stored at wr_addr on the next edge
//   wr_addr  write index
//   wr_data  byte to store
//   rd_addr  read index
//   rd_data  byte currently stored at rd_addr
module fifo_mem
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  byte_t mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule : fifo_mem

// File: rtl/uart_rx_fifo.sv
// Byte FIFO placed directly after the UART receiver.
// Each byte is captured on the receiver's one-cycle completion pulse and held
// until the consumer takes it through a valid/ready handshake. The head byte is
// shown ahead (combinationally) whenever the queue is non-empty. A byte that
// arrives while the queue is full and not being drained is dropped and the
// sticky overflow flag is raised.
//
// Ports:
//   clock           system clock, rising edge
//   reset_n         asynchronous active-low reset
//   in_data         received byte, sampled when in_valid=1
//   in_valid        one-cycle write strobe
//   out_data        head-of-queue byte, 8'h00 when empty
//   out_valid       queue non-empty
//   out_ready       consumer accepts the head byte this cycle
//   flush           synchronous empty request, highest priority
//   overflow        sticky: a byte was dropped
//   overflow_clear  clears overflow (a simultaneous drop wins)
//   count           current occupancy, 0..DEPTH
//   full            count == DEPTH
//   empty           count == 0
//   almost_full     count >= AFULL_LEVEL
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned AFULL_LEVEL = DEPTH - 2,
  localparam int unsigned ADDR_W     = $clog2(DEPTH),
  localparam int unsigned CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             flush,
  output logic             overflow,
  input  logic             overflow_clear,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             almost_full
);

  // Pointers carry one extra wrap bit above the memory index so that equal
  // indices can be told apart as either empty (same lap) or full (one lap apart).
  localparam int unsigned PTR_W = ADDR_W + 1;

  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(AFULL_LEVEL);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;

  logic             ptr_idx_equal;
  logic             ptr_wrap_equal;
  logic             full_s;
  logic             empty_s;
  logic             pop;
  logic             push;
  logic             drop;
  byte_t            head_data;

  // Status decodes from registered state only.
  assign ptr_idx_equal  = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
  assign ptr_wrap_equal = (wr_ptr_q[ADDR_W] == rd_ptr_q[ADDR_W]);
  assign full_s         = ptr_idx_equal && !ptr_wrap_equal;
  assign empty_s        = ptr_idx_equal && ptr_wrap_equal;

  // A pop frees a slot this cycle, so a write into a full queue is accepted
  // when it coincides with a pop; only an unaccompanied write is dropped.
  assign pop  = !empty_s && out_ready;
  assign push = in_valid && (!full_s || pop);
  assign drop = in_valid && full_s && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Set has priority over clear so a drop in the clearing cycle is not lost.
  always_comb begin
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (overflow_clear) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  fifo_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clock   (clock),
    .wr_en   (push && !flush),
    .wr_addr (wr_ptr_q[ADDR_W-1:0]),
    .wr_data (in_data),
    .rd_addr (rd_ptr_q[ADDR_W-1:0]),
    .rd_data (head_data)
  );

  assign out_valid   = !empty_s;
  assign out_data    = empty_s ? BYTE_ZERO : head_data;
  assign overflow    = overflow_q;
  assign count       = count_q;
  assign full        = full_s;
  assign empty       = empty_s;
  assign almost_full = (count_q >= AFULL_CNT);

  // DEPTH_CNT documents the count ceiling; count never exceeds it by design.
  logic unused_depth_cnt;
  assign unused_depth_cnt = ^DEPTH_CNT;

endmodule : uart_rx_fifo
